// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_ctrl
// Description : Frame controller behind a serial start-pattern detector.
//               It enables the detector while hunting and waits for its
//               terminal-state hit. It then captures a port address and a
//               payload length MSB-first, steers the payload bits to one of
//               2**ADDR_W ports, and clears the detector at end of frame.
// Options     : define SERIAL_FRAME_PARITY_EN to add a trailing even-parity
//               bit (PAR state) that is checked into err.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_ctrl #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serin,
  input  logic                   det_hit,
  output logic                   det_en,
  output logic                   det_rst,
  output logic                   dout,
  output logic [2**ADDR_W-1:0]   dvalid,
  output logic [ADDR_W-1:0]      port_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

`ifdef SERIAL_FRAME_PARITY_EN
  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_PAR  = 3'd4,
    S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd5
  } state_t;
`endif

  // Bits still to be sampled when entering ADDR / LEN.
  localparam logic [LEN_W-1:0] C_CNT_ADDR = LEN_W'(ADDR_W - 1);
  localparam logic [LEN_W-1:0] C_CNT_LEN  = LEN_W'(LEN_W);

  state_t                 state;
  logic [LEN_W-1:0]       cnt;
  logic [LEN_W-1:0]       len;

  // One-bit left shifts of the capture registers with serin entering the LSB.
  logic [ADDR_W:0]        addr_cat;
  logic [LEN_W:0]         len_cat;
  logic [ADDR_W-1:0]      addr_next;
  logic [LEN_W-1:0]       len_next;

  assign addr_cat  = {port_addr, serin};
  assign len_cat   = {len, serin};
  assign addr_next = addr_cat[ADDR_W-1:0];
  assign len_next  = len_cat[LEN_W-1:0];

`ifdef SERIAL_FRAME_PARITY_EN
  logic par;
`else
  assign err = 1'b0;
`endif

  // Frame sequencer: state, counters, capture registers and registered controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      cnt       <= '0;
      len       <= '0;
      port_addr <= '0;
      det_en    <= 1'b1;
      det_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par       <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      det_rst <= 1'b0;
      case (state)
        S_HUNT: begin
          if (det_hit) begin
            // serin on the hit edge is already the address MSB.
            port_addr <= addr_next;
            det_en    <= 1'b0;
            busy      <= 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
            par       <= serin;
            err       <= 1'b0;
`endif
            if (ADDR_W == 1) begin
              state <= S_LEN;
              cnt   <= C_CNT_LEN;
            end else begin
              state <= S_ADDR;
              cnt   <= C_CNT_ADDR;
            end
          end
        end
        S_ADDR: begin
          port_addr <= addr_next;
`ifdef SERIAL_FRAME_PARITY_EN
          par       <= par ^ serin;
`endif
          if (cnt == LEN_W'(1)) begin
            state <= S_LEN;
            cnt   <= C_CNT_LEN;
          end else begin
            cnt   <= cnt - 1'b1;
          end
        end
        S_LEN: begin
          len <= len_next;
`ifdef SERIAL_FRAME_PARITY_EN
          par <= par ^ serin;
`endif
          if (cnt == LEN_W'(1)) begin
            if (len_next != '0) begin
              state <= S_DATA;
              cnt   <= len_next;
            end else begin
`ifdef SERIAL_FRAME_PARITY_EN
              state   <= S_PAR;
`else
              state   <= S_DONE;
              done    <= 1'b1;
              det_rst <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
`ifdef SERIAL_FRAME_PARITY_EN
          par <= par ^ serin;
`endif
          if (cnt == LEN_W'(1)) begin
`ifdef SERIAL_FRAME_PARITY_EN
            state   <= S_PAR;
`else
            state   <= S_DONE;
            done    <= 1'b1;
            det_rst <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        S_PAR: begin
          // Even parity: all covered bits plus the parity bit XOR to zero.
          err     <= par ^ serin;
          state   <= S_DONE;
          done    <= 1'b1;
          det_rst <= 1'b1;
        end
`endif
        S_DONE: begin
          // det_hit is ignored here; the detector is being cleared.
          state  <= S_HUNT;
          det_en <= 1'b1;
          busy   <= 1'b0;
          cnt    <= '0;
        end
        default: begin
          state  <= S_HUNT;
          det_en <= 1'b1;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Payload steering: serin passes straight through to the addressed port.
  always_comb begin
    dout   = 1'b0;
    dvalid = '0;
    if (state == S_DATA) begin
      dout              = serin;
      dvalid[port_addr] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_ctrl
// Description : Scoreboard bench for serial_frame_ctrl. Frame tasks push the
//               expected payload bits and end-of-frame address; a negedge
//               monitor pops and compares whenever dvalid or done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       serin;
  logic       det_hit;
  logic       det_en;
  logic       det_rst;
  logic       dout;
  logic [3:0] dvalid;
  logic [1:0] port_addr;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [2:0] sb_data[$];  // {addr, payload bit}
  logic [1:0] sb_done[$];  // address expected at done

  serial_frame_ctrl #(.ADDR_W(2), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .serin     (serin),
    .det_hit   (det_hit),
    .det_en    (det_en),
    .det_rst   (det_rst),
    .dout      (dout),
    .dvalid    (dvalid),
    .port_addr (port_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented payload bit and every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (dvalid != 4'b0) begin
        if (sb_data.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dvalid: got %b expected 0000", dvalid);
        end else begin
          logic [2:0] e;
          e = sb_data.pop_front();
          chk("dvalid", {28'b0, dvalid}, {28'b0, 4'b0001 << e[2:1]});
          chk("dout", {31'b0, dout}, {31'b0, e[0]});
        end
      end
      if (done) begin
        if (sb_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          logic [1:0] a;
          a = sb_done.pop_front();
          chk("done_addr", {30'b0, port_addr}, {30'b0, a});
        end
      end
    end
  end

  task automatic send(input logic b, input logic h);
    serin   = b;
    det_hit = h;
    @(posedge clk);
    #1;
  endtask

  // Drive one complete frame; spur keeps det_hit high after the hit edge.
  task automatic frame(input logic [1:0] a, input logic [3:0] l, input logic [14:0] pay,
                       input bit spur, input bit bad_par);
    logic p;
    p = ^a ^ ^l;
    send(a[1], 1'b1);
    chk("err_clear_on_addr", {31'b0, err}, 32'd0);
    chk("busy_in_frame", {31'b0, busy}, 32'd1);
    chk("det_en_in_frame", {31'b0, det_en}, 32'd0);
    send(a[0], spur);
    for (int i = 3; i >= 0; i--) send(l[i], spur);
    for (int i = 0; i < int'(l); i++) begin
      sb_data.push_back({a, pay[i]});
      p = p ^ pay[i];
      send(pay[i], spur);
    end
`ifdef SERIAL_FRAME_PARITY_EN
    send(p ^ bad_par, spur);
    chk("err", {31'b0, err}, {31'b0, bad_par});
`else
    chk("err", {31'b0, err}, 32'd0);
`endif
    sb_done.push_back(a);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("det_rst_pulse", {31'b0, det_rst}, 32'd1);
    chk("det_en_done", {31'b0, det_en}, 32'd0);
    send(1'b0, spur);
    det_hit = 1'b0;
    chk("done_after", {31'b0, done}, 32'd0);
    chk("det_rst_after", {31'b0, det_rst}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("det_en_hunt", {31'b0, det_en}, 32'd1);
    chk("port_addr_held", {30'b0, port_addr}, {30'b0, a});
    send(1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_det_en", {31'b0, det_en}, 32'd1);
    chk("rst_det_rst", {31'b0, det_rst}, 32'd0);
    chk("rst_dout", {31'b0, dout}, 32'd0);
    chk("rst_dvalid", {28'b0, dvalid}, 32'd0);
    chk("rst_port_addr", {30'b0, port_addr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; serin = 1'b0; det_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    repeat (2) send(1'b0, 1'b0);

    // Basic frame: addr 10, len 3, payload 1,0,1.
    frame(2'b10, 4'd3, 15'b101, 1'b0, 1'b0);
    // Zero length: addr 01.
    frame(2'b01, 4'd0, 15'b0, 1'b0, 1'b0);
    // Maximum length: addr 11, 15 payload bits.
    frame(2'b11, 4'd15, 15'h5A3C, 1'b0, 1'b0);
    // det_hit held high through the whole frame.
    frame(2'b01, 4'd2, 15'b10, 1'b1, 1'b0);
    frame(2'b00, 4'd1, 15'b1, 1'b0, 1'b0);

    // Reset in the middle of DATA: partial frame discarded, no done.
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    sb_data.push_back(3'b101); send(1'b1, 1'b0);
    sb_data.push_back(3'b100); send(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; serin = 1'b0;
    send(1'b0, 1'b0);
    frame(2'b10, 4'd3, 15'b110, 1'b0, 1'b0);

`ifdef SERIAL_FRAME_PARITY_EN
    // Correct parity bit, then corrupted parity, then a clean frame clears err.
    frame(2'b00, 4'd1, 15'b0, 1'b0, 1'b0);
    frame(2'b00, 4'd1, 15'b0, 1'b0, 1'b1);
    chk("err_held", {31'b0, err}, 32'd1);
    frame(2'b11, 4'd2, 15'b11, 1'b0, 1'b0);
`endif

    repeat (2) send(1'b0, 1'b0);
    chk("sb_data_empty", sb_data.size(), 32'd0);
    chk("sb_done_empty", sb_done.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
